// File: rtl/chaotic_fx_term_joiner.sv
// rtl/chaotic_fx_term_joiner.sv - yn1 = b*xn + d*yn*wn with arrival-order operand alignment (optional CHAOS_FX_SAT_EN)

module chaotic_fx_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic [LVL_W-1:0] level,
    output logic             empty,
    output logic             drop
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full, push_ok;

    // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle
    always_comb begin
        full     = (level_q == LVL_W'(DEPTH));
        push_ok  = push && (!full || pop);
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q + LVL_W'(push_ok) - LVL_W'(pop);
    end

    // Storage needs no reset: entries are only read after being written
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign level = level_q;
    assign empty = (level_q == '0);
    assign drop  = push && !push_ok;
endmodule

module chaotic_fx_term_joiner #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] b,
    input  logic signed [DATA_WIDTH-1:0] d,
    input  logic                         x_valid,
    input  logic signed [DATA_WIDTH-1:0] x,
    input  logic                         y_valid,
    input  logic signed [DATA_WIDTH-1:0] y,
    input  logic                         w_valid,
    input  logic signed [DATA_WIDTH-1:0] w,
    input  logic                         err_clr,
    output logic                         yn1_valid,
    output logic signed [DATA_WIDTH-1:0] yn1,
    output logic [LVL_W-1:0]             x_level,
    output logic [LVL_W-1:0]             y_level,
    output logic                         ovf_err,
    output logic                         udf_err
);
    localparam int DW = DATA_WIDTH;
`ifdef CHAOS_FX_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    localparam logic [DW-1:0] MAX_V = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MIN_V = {1'b1, {(DW-1){1'b0}}};

    // Full-width signed product via sign extension (low 2*DW bits are exact)
    function automatic logic [2*DW-1:0] smul(input logic [DW-1:0] a, input logic [DW-1:0] c);
        smul = {{DW{a[DW-1]}}, a} * {{DW{c[DW-1]}}, c};
    endfunction

    // Floor shift by FRAC_BITS, then saturate or wrap to DW bits
    function automatic logic [DW-1:0] scale(input logic [2*DW-1:0] p);
        logic [2*DW-1:0] s;
        logic            ovf;
        s   = $unsigned($signed(p) >>> FRAC_BITS);
        ovf = !((&s[2*DW-1:DW-1]) || !(|s[2*DW-1:DW-1]));
        if (SAT_EN && ovf) scale = s[2*DW-1] ? MIN_V : MAX_V;
        else               scale = s[DW-1:0];
    endfunction

    // Signed add with saturation or wrap
    function automatic logic [DW-1:0] add_sat(input logic [DW-1:0] a, input logic [DW-1:0] c);
        logic [DW:0] sum;
        sum = {a[DW-1], a} + {c[DW-1], c};
        if (SAT_EN && (sum[DW] ^ sum[DW-1])) add_sat = sum[DW] ? MIN_V : MAX_V;
        else                                 add_sat = sum[DW-1:0];
    endfunction

    logic [1:0]      rst_sync_q, rst_sync_d;
    logic            rst_int_n;
    logic            xs_v_q, xs_v_d, ys_v_q, ys_v_d;
    logic [DW-1:0]   xs_x_q, xs_x_d, xs_b_q, xs_b_d, ys_y_q, ys_y_d, ys_d_q, ys_d_d;
    logic            bxp_v_q, bxp_v_d, dyp_v_q, dyp_v_d;
    logic [2*DW-1:0] bxp_q, bxp_d, dyp_q, dyp_d;
    logic            s1_v_q, s1_v_d, s2_v_q, s2_v_d, out_v_q, out_v_d;
    logic [DW-1:0]   s1_w_q, s1_w_d, s1_bx_q, s1_bx_d, s1_dy_q, s1_dy_d;
    logic [2*DW-1:0] s2_p_q, s2_p_d;
    logic [DW-1:0]   s2_bx_q, s2_bx_d, out_q, out_d;
    logic            ovf_q, ovf_d, udf_q, udf_d;
    logic            pop, udf_evt, x_empty, y_empty, x_drop, y_drop;
    logic [DW-1:0]   x_push_data, y_push_data, x_head, y_head;

    // Reset asserts immediately, releases two clocks after rst_n rises
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    // Reset synchroniser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= rst_sync_d;
    end

    assign rst_int_n = rst_sync_q[1];

    chaotic_fx_fifo #(.W(DW), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_bx_fifo (
        .clk(clk), .rst_n(rst_int_n), .push(bxp_v_q), .push_data(x_push_data),
        .pop(pop), .head(x_head), .level(x_level), .empty(x_empty), .drop(x_drop)
    );

    chaotic_fx_fifo #(.W(DW), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_dy_fifo (
        .clk(clk), .rst_n(rst_int_n), .push(dyp_v_q), .push_data(y_push_data),
        .pop(pop), .head(y_head), .level(y_level), .empty(y_empty), .drop(y_drop)
    );

    // Operand paths, pairing/pop decision, result pipeline and sticky flags
    always_comb begin
        x_push_data = scale(bxp_q);
        y_push_data = scale(dyp_q);
        pop         = w_valid && !x_empty && !y_empty;
        udf_evt     = w_valid && (x_empty || y_empty);

        xs_v_d  = x_valid;
        xs_x_d  = x_valid ? x : xs_x_q;
        xs_b_d  = x_valid ? b : xs_b_q;
        ys_v_d  = y_valid;
        ys_y_d  = y_valid ? y : ys_y_q;
        ys_d_d  = y_valid ? d : ys_d_q;

        bxp_v_d = xs_v_q;
        bxp_d   = xs_v_q ? smul(xs_b_q, xs_x_q) : bxp_q;
        dyp_v_d = ys_v_q;
        dyp_d   = ys_v_q ? smul(ys_d_q, ys_y_q) : dyp_q;

        s1_v_d  = pop;
        s1_w_d  = pop ? w : s1_w_q;
        s1_bx_d = pop ? x_head : s1_bx_q;
        s1_dy_d = pop ? y_head : s1_dy_q;

        s2_v_d  = s1_v_q;
        s2_p_d  = s1_v_q ? smul(s1_dy_q, s1_w_q) : s2_p_q;
        s2_bx_d = s1_v_q ? s1_bx_q : s2_bx_q;

        out_v_d = s2_v_q;
        out_d   = s2_v_q ? add_sat(s2_bx_q, scale(s2_p_q)) : out_q;

        ovf_d   = (err_clr ? 1'b0 : ovf_q) | x_drop | y_drop;
        udf_d   = (err_clr ? 1'b0 : udf_q) | udf_evt;
    end

    // Pipeline state
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            xs_v_q <= 1'b0; xs_x_q <= '0; xs_b_q <= '0;
            ys_v_q <= 1'b0; ys_y_q <= '0; ys_d_q <= '0;
            bxp_v_q <= 1'b0; bxp_q <= '0; dyp_v_q <= 1'b0; dyp_q <= '0;
            s1_v_q <= 1'b0; s1_w_q <= '0; s1_bx_q <= '0; s1_dy_q <= '0;
            s2_v_q <= 1'b0; s2_p_q <= '0; s2_bx_q <= '0;
            out_v_q <= 1'b0; out_q <= '0;
            ovf_q <= 1'b0; udf_q <= 1'b0;
        end else begin
            xs_v_q <= xs_v_d; xs_x_q <= xs_x_d; xs_b_q <= xs_b_d;
            ys_v_q <= ys_v_d; ys_y_q <= ys_y_d; ys_d_q <= ys_d_d;
            bxp_v_q <= bxp_v_d; bxp_q <= bxp_d; dyp_v_q <= dyp_v_d; dyp_q <= dyp_d;
            s1_v_q <= s1_v_d; s1_w_q <= s1_w_d; s1_bx_q <= s1_bx_d; s1_dy_q <= s1_dy_d;
            s2_v_q <= s2_v_d; s2_p_q <= s2_p_d; s2_bx_q <= s2_bx_d;
            out_v_q <= out_v_d; out_q <= out_d;
            ovf_q <= ovf_d; udf_q <= udf_d;
        end
    end

    assign yn1_valid = out_v_q;
    assign yn1       = out_q;
    assign ovf_err   = ovf_q;
    assign udf_err   = udf_q;
endmodule

// File: tb/tb_chaotic_fx_term_joiner.sv
// tb/tb_chaotic_fx_term_joiner.sv - directed self-checking bench for chaotic_fx_term_joiner

module tb_chaotic_fx_term_joiner;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] b, d, x, y, w;
    logic        x_valid, y_valid, w_valid, err_clr;
    logic        yn1_valid;
    logic [31:0] yn1;
    logic [2:0]  x_level, y_level;
    logic        ovf_err, udf_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0, t1;

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } rec_t;
    rec_t res_q[$];

`ifdef CHAOS_FX_SAT_EN
    localparam logic [31:0] EXP_SAT = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] EXP_SAT = 32'hFFFE_0000;
`endif

    chaotic_fx_term_joiner #(
        .DATA_WIDTH(32), .FRAC_BITS(16), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .b(b), .d(d),
        .x_valid(x_valid), .x(x), .y_valid(y_valid), .y(y),
        .w_valid(w_valid), .w(w), .err_clr(err_clr),
        .yn1_valid(yn1_valid), .yn1(yn1),
        .x_level(x_level), .y_level(y_level),
        .ovf_err(ovf_err), .udf_err(udf_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (yn1_valid === 1'b1) res_q.push_back('{cyc, yn1});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_q(input string tag, input int exp_cyc0, input int n,
                         input logic [31:0] v0, input logic [31:0] dv);
        logic [31:0] ev;
        chk($sformatf("%s count", tag), 32'(res_q.size()), 32'(n));
        ev = v0;
        for (int i = 0; i < n && i < res_q.size(); i++) begin
            chk($sformatf("%s cyc%0d", tag, i), 32'(res_q[i].cyc), 32'(exp_cyc0 + i));
            chk($sformatf("%s val%0d", tag, i), res_q[i].val, ev);
            ev = ev + dv;
        end
    endtask

    task automatic idle();
        x_valid = 1'b0; y_valid = 1'b0; w_valid = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; b = '0; d = '0; x = '0; y = '0; w = '0;
        idle();
        repeat (3) tick();
        chk("rst yn1_valid", 32'(yn1_valid), 32'd0);
        chk("rst yn1", yn1, 32'd0);
        chk("rst x_level", 32'(x_level), 32'd0);
        chk("rst y_level", 32'(y_level), 32'd0);
        chk("rst errs", {30'd0, ovf_err, udf_err}, 32'd0);
        rst_n = 1'b1;
        repeat (4) tick();

        // Basic: 2.0*1.0 + 0.5*4.0*0.5 = 3.0
        res_q.delete();
        t0 = cyc;
        b = 32'h0002_0000; d = 32'h0000_8000; x = 32'h0001_0000; y = 32'h0004_0000;
        x_valid = 1'b1; y_valid = 1'b1;
        tick(); idle();
        tick();
        chk("s1 x_level before push", 32'(x_level), 32'd0);
        tick();
        chk("s1 x_level after push", 32'(x_level), 32'd1);
        chk("s1 y_level after push", 32'(y_level), 32'd1);
        tick(); tick();
        w = 32'h0000_8000; w_valid = 1'b1;
        tick(); idle();
        repeat (4) tick();
        chk("s1 x_level drained", 32'(x_level), 32'd0);
        chk("s1 y_level drained", 32'(y_level), 32'd0);
        chk_q("s1", t0 + 8, 1, 32'h0003_0000, 32'd0);

        // Saturation / wrap of the bx scaling
        res_q.delete();
        t0 = cyc;
        b = 32'h7FFF_0000; x = 32'h0002_0000; d = 32'h0001_0000; y = 32'd0;
        x_valid = 1'b1; y_valid = 1'b1;
        tick(); idle();
        tick(); tick();
        w = 32'd0; w_valid = 1'b1;
        tick(); idle();
        repeat (5) tick();
        chk_q("s2", t0 + 6, 1, EXP_SAT, 32'd0);

        // Underflow, clear, recovery
        res_q.delete();
        chk("s3 udf before", 32'(udf_err), 32'd0);
        w = 32'h0001_0000; w_valid = 1'b1;
        tick(); idle();
        chk("s3 udf set", 32'(udf_err), 32'd1);
        repeat (4) tick();
        chk_q("s3 no result", 0, 0, 32'd0, 32'd0);
        err_clr = 1'b1;
        tick(); idle();
        chk("s3 udf cleared", 32'(udf_err), 32'd0);
        t0 = cyc;
        b = 32'h0001_0000; d = 32'h0001_0000; x = 32'h0003_0000; y = 32'h0002_0000;
        x_valid = 1'b1; y_valid = 1'b1;
        tick(); idle();
        tick(); tick();
        w = 32'h0001_8000; w_valid = 1'b1;
        tick(); idle();
        repeat (5) tick();
        chk_q("s3", t0 + 6, 1, 32'h0006_0000, 32'd0);
        chk("s3 udf stays clear", 32'(udf_err), 32'd0);

        // Overflow: fifth x dropped, four results from the first four x
        res_q.delete();
        b = 32'h0001_0000; d = 32'h0001_0000;
        for (int i = 0; i < 5; i++) begin
            x = 32'(i + 1) << 16; x_valid = 1'b1;
            tick();
        end
        idle();
        repeat (4) tick();
        chk("s4 x_level full", 32'(x_level), 32'd4);
        chk("s4 ovf set", 32'(ovf_err), 32'd1);
        chk("s4 y_level", 32'(y_level), 32'd0);
        for (int i = 0; i < 4; i++) begin
            y = 32'h0001_0000; y_valid = 1'b1;
            tick();
        end
        idle();
        repeat (3) tick();
        chk("s4 y_level full", 32'(y_level), 32'd4);
        t1 = cyc;
        for (int i = 0; i < 4; i++) begin
            w = 32'h0001_0000; w_valid = 1'b1;
            tick();
        end
        idle();
        repeat (5) tick();
        chk_q("s4", t1 + 3, 4, 32'h0002_0000, 32'h0001_0000);
        chk("s4 x_level drained", 32'(x_level), 32'd0);
        chk("s4 udf", 32'(udf_err), 32'd0);
        err_clr = 1'b1;
        tick(); idle();
        chk("s4 ovf cleared", 32'(ovf_err), 32'd0);

        // Burst: eight back-to-back triples
        res_q.delete();
        b = 32'h0001_0000; d = 32'h0001_0000;
        t0 = cyc;
        for (int i = 0; i < 11; i++) begin
            x_valid = (i < 8); x = 32'(i) << 16;
            y_valid = (i < 8); y = 32'h0001_0000;
            w_valid = (i >= 3); w = 32'h0001_0000;
            tick();
        end
        idle();
        repeat (5) tick();
        chk_q("s5", t0 + 6, 8, 32'h0001_0000, 32'h0001_0000);
        chk("s5 errs", {30'd0, ovf_err, udf_err}, 32'd0);

        // Reset mid-burst flushes everything in flight
        res_q.delete();
        for (int i = 0; i < 4; i++) begin
            x_valid = 1'b1; x = 32'(i) << 16;
            y_valid = 1'b1; y = 32'h0001_0000;
            w_valid = (i >= 3); w = 32'h0001_0000;
            tick();
        end
        rst_n = 1'b0;
        idle();
        #1;
        chk("s6 yn1_valid", 32'(yn1_valid), 32'd0);
        chk("s6 yn1", yn1, 32'd0);
        chk("s6 x_level", 32'(x_level), 32'd0);
        chk("s6 y_level", 32'(y_level), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk_q("s6 flushed", 0, 0, 32'd0, 32'd0);
        t0 = cyc;
        x = 32'h0005_0000; y = 32'h0001_0000; x_valid = 1'b1; y_valid = 1'b1;
        tick(); idle();
        tick(); tick();
        w = 32'h0001_0000; w_valid = 1'b1;
        tick(); idle();
        repeat (5) tick();
        chk_q("s6 recover", t0 + 6, 1, 32'h0006_0000, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
